// File: rtl/cpu_trace_buffer_pkg.sv
// Shared widths and helpers for the CPU trace buffer slice.
// A trace entry is {pc, reg0, seq}, so its width is derived from the two field widths.
package cpu_trace_buffer_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_SEQ_W  = 8;

    function automatic int trace_width(input int data_w, input int seq_w);
        return 2 * data_w + seq_w;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_trace_fifo.sv
// Synchronous first-word-fall-through FIFO for packed trace entries.
// When empty, dout keeps showing the most recently popped entry instead of stale storage.
module cpu_trace_buffer_trace_fifo #(
    parameter int WIDTH  = 40,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  hold;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic              empty;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    // When full, wr_ptr equals rd_ptr; the head is read combinationally before this write lands.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = empty ? hold : mem[rd_ptr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace monitor for cpu_behav: logs {pc, reg0, seq} on every PC change into a FIFO
// drained over valid/ready; captures lost to a full FIFO are counted and flagged.
module cpu_trace_buffer
    import cpu_trace_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SEQ_W  = DEF_SEQ_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] prog_cnt,
    input  logic [DATA_W-1:0] reg0,
    input  logic              capture_en,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_reg0,
    output logic [SEQ_W-1:0]  out_seq,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [DATA_W-1:0] drop_cnt
);

    localparam int              TRACE_W    = trace_width(DATA_W, SEQ_W);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  last_pc;
    logic               armed;
    logic [SEQ_W-1:0]   seq;
    logic               cap;
    logic               pop;
    logic               push;
    logic               drop;
    logic               full;
    logic [TRACE_W-1:0] fifo_din;
    logic [TRACE_W-1:0] fifo_dout;

    // armed forces the very first enabled sample to be logged even if the PC matches last_pc.
    assign cap  = capture_en && (armed || (prog_cnt != last_pc));
    assign full = (count == FULL_COUNT);
    assign pop  = out_valid && out_ready;
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    assign out_valid = (count != '0);
    assign fifo_din  = {prog_cnt, reg0, seq};

    // seq advances on drops too, so the consumer can spot gaps in the numbering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc  <= '0;
            armed    <= 1'b1;
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            last_pc  <= '0;
            armed    <= 1'b1;
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (cap) begin
                last_pc <= prog_cnt;
                armed   <= 1'b0;
                seq     <= seq + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    cpu_trace_buffer_trace_fifo #(
        .WIDTH  (TRACE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count)
    );

    assign {out_pc, out_reg0, out_seq} = fifo_dout;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: a vector table for change detection and drain,
// plus hand sequences for overflow, full push/pop, latency, clear and async reset.
module tb_cpu_trace_buffer;

    logic        clk;
    logic        rst;
    logic [15:0] prog_cnt;
    logic [15:0] reg0;
    logic        capture_en;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_reg0;
    logic [7:0]  out_seq;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int num_checks;
    int num_errors;

    typedef struct {
        logic        cap_en;
        logic        clr;
        logic        rdy;
        logic [15:0] pc;
        logic [15:0] r0;
        logic        exp_valid;
        logic [4:0]  exp_count;
        logic        exp_ovf;
        logic [15:0] exp_drop;
        logic        chk_head;
        logic [15:0] exp_pc;
        logic [15:0] exp_r0;
        logic [7:0]  exp_seq;
    } vec_t;

    vec_t vecs [12];

    cpu_trace_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .prog_cnt   (prog_cnt),
        .reg0       (reg0),
        .capture_en (capture_en),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_reg0   (out_reg0),
        .out_seq    (out_seq),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge, so outputs are sampled well away from it.
    task automatic apply_stimulus(input logic cap_en, input logic clr, input logic rdy,
                                  input logic [15:0] pc, input logic [15:0] r0);
        capture_en = cap_en;
        clear      = clr;
        out_ready  = rdy;
        prog_cnt   = pc;
        reg0       = r0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [15:0] pc, input logic [15:0] r0,
                              input logic [7:0] sq);
        check_output({tag, ".valid"}, 32'(out_valid), 32'd1);
        check_output({tag, ".pc"}, 32'(out_pc), 32'(pc));
        check_output({tag, ".reg0"}, 32'(out_reg0), 32'(r0));
        check_output({tag, ".seq"}, 32'(out_seq), 32'(sq));
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 16'd5, 1'b1, 5'd1, 1'b0, 16'd0, 1'b1, 16'd0, 16'd5, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'd0, 16'd5, 1'b1, 5'd1, 1'b0, 16'd0, 1'b1, 16'd0, 16'd5, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'd1, 16'd6, 1'b1, 5'd2, 1'b0, 16'd0, 1'b1, 16'd0, 16'd5, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'd1, 16'd6, 1'b1, 5'd2, 1'b0, 16'd0, 1'b1, 16'd0, 16'd5, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'd2, 16'd7, 1'b1, 5'd3, 1'b0, 16'd0, 1'b1, 16'd0, 16'd5, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'd2, 16'd7, 1'b1, 5'd2, 1'b0, 16'd0, 1'b1, 16'd1, 16'd6, 8'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'd2, 16'd7, 1'b1, 5'd1, 1'b0, 16'd0, 1'b1, 16'd2, 16'd7, 8'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'd2, 16'd7, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'd2, 16'd7, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 8'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'd3, 16'd8, 1'b1, 5'd1, 1'b0, 16'd0, 1'b1, 16'd3, 16'd8, 8'd3};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'd3, 16'd8, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 8'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'd3, 16'd8, 1'b0, 5'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0, 8'd0};

        rst        = 1'b0;
        capture_en = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;
        prog_cnt   = '0;
        reg0       = '0;

        repeat (2) @(posedge clk);
        #1;
        check_output("rst.valid", 32'(out_valid), 32'd0);
        check_output("rst.count", 32'(count), 32'd0);
        check_output("rst.overflow", 32'(overflow), 32'd0);
        check_output("rst.drop_cnt", 32'(drop_cnt), 32'd0);
        check_output("rst.out_pc", 32'(out_pc), 32'd0);
        check_output("rst.out_seq", 32'(out_seq), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_rst.valid", 32'(out_valid), 32'd0);
        check_output("post_rst.count", 32'(count), 32'd0);

        // PC change detection, drain, re-enable on unchanged PC, then clear.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].cap_en, vecs[i].clr, vecs[i].rdy, vecs[i].pc, vecs[i].r0);
            check_output($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            check_output($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check_output($sformatf("vec%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
            if (vecs[i].chk_head) begin
                check_head($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_r0, vecs[i].exp_seq);
            end
        end

        // Overflow: 20 distinct PCs into 16 slots with no consumer.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 16'(100 + i), 16'(i));
            check_output($sformatf("ovf%0d.count", i), 32'(count), (i < 16) ? 32'(i + 1) : 32'd16);
            check_output($sformatf("ovf%0d.drop_cnt", i), 32'(drop_cnt), (i < 16) ? 32'd0 : 32'(i - 15));
            check_output($sformatf("ovf%0d.overflow", i), 32'(overflow), (i < 16) ? 32'd0 : 32'd1);
        end
        check_head("ovf.head", 16'd100, 16'd0, 8'd0);

        // Full FIFO with simultaneous pop and a new capture.
        apply_stimulus(1'b1, 1'b0, 1'b1, 16'd200, 16'd55);
        check_output("full_pp.count", 32'(count), 32'd16);
        check_output("full_pp.drop_cnt", 32'(drop_cnt), 32'd4);
        check_output("full_pp.overflow", 32'(overflow), 32'd1);
        check_head("full_pp.head", 16'd101, 16'd1, 8'd1);

        // Drain: seq 1..15 then the resumed entry carrying seq 20 after the gap.
        for (int k = 0; k < 16; k++) begin
            if (k < 15) begin
                check_head($sformatf("drain%0d", k), 16'(101 + k), 16'(1 + k), 8'(1 + k));
            end else begin
                check_head("drain15", 16'd200, 16'd55, 8'd20);
            end
            apply_stimulus(1'b0, 1'b0, 1'b1, 16'd200, 16'd55);
        end
        check_output("drained.valid", 32'(out_valid), 32'd0);
        check_output("drained.count", 32'(count), 32'd0);

        // Latency and backpressure.
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd300, 16'd9);
        check_output("lat.count", 32'(count), 32'd1);
        check_head("lat.head", 16'd300, 16'd9, 8'd21);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 16'd300, 16'd9);
            check_head($sformatf("bp%0d", k), 16'd300, 16'd9, 8'd21);
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, 16'd300, 16'd9);
        check_output("lat_pop.valid", 32'(out_valid), 32'd0);
        check_output("lat_pop.count", 32'(count), 32'd0);

        // Clear with occupancy 5, overflow set, and a capture in the same cycle.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 16'(400 + i), 16'(i));
        end
        check_output("pre_clr.count", 32'(count), 32'd5);
        check_output("pre_clr.overflow", 32'(overflow), 32'd1);
        check_head("pre_clr.head", 16'd400, 16'd0, 8'd22);
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'd405, 16'd66);
        check_output("clr.count", 32'(count), 32'd0);
        check_output("clr.valid", 32'(out_valid), 32'd0);
        check_output("clr.overflow", 32'(overflow), 32'd0);
        check_output("clr.drop_cnt", 32'(drop_cnt), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd405, 16'd77);
        check_output("post_clr.count", 32'(count), 32'd1);
        check_head("post_clr.head", 16'd405, 16'd77, 8'd0);

        // Asynchronous reset while an entry is waiting: it must vanish without a clock edge.
        capture_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_output("async_rst.valid", 32'(out_valid), 32'd0);
        check_output("async_rst.count", 32'(count), 32'd0);
        check_output("async_rst.out_pc", 32'(out_pc), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
        $finish;
    end

endmodule
